conv_pass_sequencer: RTL and testbench

CONV_PASS_SEQUENCER -- requirements
Module: conv_pass_sequencer

---
 rtl/eyeriss_pkg.sv | 38 +++
 rtl/conv_pass_sequencer_wrap_cnt.sv | 30 +++
 rtl/conv_pass_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pkg.sv
// Shared types for the conv pass sequencer: FSM state encoding, width defaults,
// the latched layer-shape record and the shape legality test.
package eyeriss_pkg;

  localparam int CW_DEF = 16;
  localparam int PW_DEF = 5;
  // Shape fields are sized to the widest supported CW/PW so one struct serves any build.
  localparam int SHP_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_LD_FILT = 3'd2,
    ST_LD_IFM  = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_FIN     = 3'd6,
    ST_ERR     = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic [SHP_W-1:0] p;
    logic [SHP_W-1:0] q;
    logic [SHP_W-1:0] r;
    logic [SHP_W-1:0] t;
    logic [SHP_W-1:0] R;
    logic [SHP_W-1:0] S;
    logic [SHP_W-1:0] H;
    logic [SHP_W-1:0] W;
  } shape_t;

  function automatic logic shape_bad(input shape_t s);
    return (s.p == '0) || (s.q == '0) || (s.r == '0) || (s.t == '0) ||
           (s.R == '0) || (s.S == '0) || (s.H == '0) || (s.W == '0) ||
           (s.R > s.H) || (s.S > s.W);
  endfunction

endpackage

// File: rtl/conv_pass_sequencer_wrap_cnt.sv
// wrap_cnt: index counter running 0..limit-1; wrap pulses on the increment that
// returns it to 0. clr has priority over inc.
module wrap_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic at_last;

  assign at_last = (count == limit - W'(1));
  assign wrap    = inc && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: walks one conv-layer pass (groups x rows) issuing filter and
// ifmap loads, PE compute windows and psum drains. SEQ_PERF_CNT_EN adds cyc_cnt/stall_cnt.
module conv_pass_sequencer
  import eyeriss_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alarm,
  input  logic [PW-1:0] p,
  input  logic [PW-1:0] q,
  input  logic [PW-1:0] r,
  input  logic [PW-1:0] t,
  input  logic [PW-1:0] R,
  input  logic [PW-1:0] S,
  input  logic [CW-1:0] H,
  input  logic [CW-1:0] W,
  output logic          filt_req,
  input  logic          filt_ack,
  output logic          ifm_req,
  input  logic          ifm_ack,
  output logic          pe_en,
  output logic          psum_valid,
  input  logic          psum_ready,
  output logic [PW-1:0] grp_idx,
  output logic [CW-1:0] row_idx,
  output logic [CW-1:0] col_idx,
  output logic [PW-1:0] tap_idx,
  output logic          busy,
  output logic          done,
  output seq_state_e    state,
  output logic          cfg_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  // Handshakes: a req/valid is high for the whole state that owns it and a transfer
  // happens on a rising edge where both it and its ack/ready are high; an ack or
  // ready seen while the request is low has no effect.

  seq_state_e    state_q, state_d;
  shape_t        shp;
  logic [CW-1:0] e_lim, f_lim;
  logic          cfg_err_q;
  logic          accept;

  logic grp_clr, grp_inc, grp_wrap;
  logic row_clr, row_inc, row_wrap;
  logic col_clr, col_inc, col_wrap;
  logic tap_clr, tap_inc, tap_wrap;

  assign accept = (state_q == ST_IDLE) && alarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shp <= '0;
    end else if (accept) begin
      shp <= '{p: SHP_W'(p), q: SHP_W'(q), r: SHP_W'(r), t: SHP_W'(t),
               R: SHP_W'(R), S: SHP_W'(S), H: SHP_W'(H), W: SHP_W'(W)};
    end
  end

  // Output extents are derived once while in CFG and then stay constant for the pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_lim <= '0;
      f_lim <= '0;
    end else if (state_q == ST_CFG) begin
      e_lim <= CW'(shp.H - shp.R + SHP_W'(1));
      f_lim <= CW'(shp.W - shp.S + SHP_W'(1));
    end
  end

  // cfg_err rises entering ERR and stays until the next accepted alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else if (accept) begin
      cfg_err_q <= 1'b0;
    end else if ((state_q == ST_CFG) && shape_bad(shp)) begin
      cfg_err_q <= 1'b1;
    end
  end

  // Counter controls are kept outside the FSM process so the wrap pulses can feed it.
  assign tap_clr = (state_q == ST_LD_IFM) && ifm_ack;
  assign tap_inc = (state_q == ST_COMPUTE);
  assign col_clr = tap_clr;
  assign col_inc = (state_q == ST_COMPUTE) ? tap_wrap
                                           : ((state_q == ST_DRAIN) && psum_ready);
  assign row_clr = (state_q == ST_CFG);
  assign row_inc = (state_q == ST_DRAIN) && col_wrap;
  assign grp_clr = (state_q == ST_CFG);
  assign grp_inc = row_wrap;

  wrap_cnt #(.W(PW)) u_grp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grp_clr),
    .inc   (grp_inc),
    .limit (shp.t[PW-1:0]),
    .count (grp_idx),
    .wrap  (grp_wrap)
  );

  wrap_cnt #(.W(CW)) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (row_clr),
    .inc   (row_inc),
    .limit (e_lim),
    .count (row_idx),
    .wrap  (row_wrap)
  );

  wrap_cnt #(.W(CW)) u_col_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (col_clr),
    .inc   (col_inc),
    .limit (f_lim),
    .count (col_idx),
    .wrap  (col_wrap)
  );

  wrap_cnt #(.W(PW)) u_tap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tap_clr),
    .inc   (tap_inc),
    .limit (shp.S[PW-1:0]),
    .count (tap_idx),
    .wrap  (tap_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (alarm) state_d = ST_CFG;
      ST_CFG:     state_d = shape_bad(shp) ? ST_ERR : ST_LD_FILT;
      ST_LD_FILT: if (filt_ack) state_d = ST_LD_IFM;
      ST_LD_IFM:  if (ifm_ack) state_d = ST_COMPUTE;
      ST_COMPUTE: if (col_wrap) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (col_wrap) begin
          if (!row_wrap) begin
            state_d = ST_LD_IFM;
          end else begin
            state_d = grp_wrap ? ST_FIN : ST_LD_FILT;
          end
        end
      end
      ST_FIN:     state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign filt_req   = (state_q == ST_LD_FILT);
  assign ifm_req    = (state_q == ST_LD_IFM);
  assign pe_en      = (state_q == ST_COMPUTE);
  assign psum_valid = (state_q == ST_DRAIN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign state      = state_q;
  assign cfg_err    = cfg_err_q;

`ifdef SEQ_PERF_CNT_EN
  logic stall;

  assign stall = (filt_req && !filt_ack) || (ifm_req && !ifm_ack) ||
                 (psum_valid && !psum_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (accept) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Scoreboard bench for conv_pass_sequencer: directed passes push expected psum beats and
// done pulses; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_conv_pass_sequencer;
  import eyeriss_pkg::*;

  localparam int CW   = 16;
  localparam int PW   = 5;
  localparam int SB_W = 1 + PW + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alarm = 1'b0;
  logic [PW-1:0] sp = '0, sq = '0, sr = '0, st = '0, s_r = '0, s_s = '0;
  logic [CW-1:0] s_h = '0, s_w = '0;
  logic          filt_req, filt_ack, ifm_req, ifm_ack;
  logic          pe_en, psum_valid, psum_ready;
  logic [PW-1:0] grp_idx, tap_idx;
  logic [CW-1:0] row_idx, col_idx;
  logic          busy, done, cfg_err;
  seq_state_e    state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   cyc_cnt, stall_cnt;
`endif

  conv_pass_sequencer #(.CW(CW), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alarm      (alarm),
    .p          (sp),
    .q          (sq),
    .r          (sr),
    .t          (st),
    .R          (s_r),
    .S          (s_s),
    .H          (s_h),
    .W          (s_w),
    .filt_req   (filt_req),
    .filt_ack   (filt_ack),
    .ifm_req    (ifm_req),
    .ifm_ack    (ifm_ack),
    .pe_en      (pe_en),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .grp_idx    (grp_idx),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .tap_idx    (tap_idx),
    .busy       (busy),
    .done       (done),
    .state      (state),
    .cfg_err    (cfg_err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // clock / reset-free responders
  always #5 clk = ~clk;

  int   filt_delay = 0;
  logic bp_mode = 1'b0;
  int   f_wait = 0;
  int   d_cnt = 0;

  assign filt_ack   = filt_req && (f_wait >= filt_delay);
  assign ifm_ack    = ifm_req;
  assign psum_ready = bp_mode ? ((d_cnt % 2) == 0) : 1'b1;

  always @(posedge clk) begin
    f_wait <= (filt_req && !filt_ack) ? f_wait + 1 : 0;
    d_cnt  <= psum_valid ? d_cnt + 1 : 0;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [SB_W-1:0] sb_item(input logic k, input logic [PW-1:0] g,
                                              input logic [CW-1:0] rw, input logic [CW-1:0] c);
    return {k, g, rw, c};
  endfunction

  function automatic void sb_pop(input string name, input logic [SB_W-1:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected actual=%0h required=empty", name, act);
    end else begin
      check(name, 64'(act), 64'(exp_q.pop_front()));
    end
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({filt_req, ifm_req, pe_en, psum_valid, busy, done, cfg_err,
                grp_idx, row_idx, col_idx, tap_idx, state});
  endfunction

  // monitor
  int n_filt = 0, n_ifm = 0, n_pe = 0, n_beat = 0, n_done = 0;
  int f_run = 0, f_ack_at = -1, last_f_run = 0;
  int v_run = 0, last_v_run = 0, drain_beats = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      f_run = 0;
      v_run = 0;
      drain_beats = 0;
    end else begin
      if (filt_req) begin
        if (filt_ack) begin
          n_filt++;
          f_ack_at = f_run;
        end
        f_run++;
      end else if (f_run != 0) begin
        last_f_run = f_run;
        f_run = 0;
      end
      if (ifm_req && ifm_ack) n_ifm++;
      if (pe_en) n_pe++;
      if (psum_valid) begin
        v_run++;
        check("drain_col", 64'(col_idx), 64'(drain_beats));
        if (psum_ready) begin
          n_beat++;
          drain_beats++;
          sb_pop("beat", sb_item(1'b0, grp_idx, row_idx, col_idx));
        end
      end else begin
        if (v_run != 0) last_v_run = v_run;
        v_run = 0;
        drain_beats = 0;
      end
      if (done) begin
        n_done++;
        sb_pop("done", sb_item(done, '0, '0, '0));
      end
    end
  end

  // driver tasks
  int b_filt, b_ifm, b_pe, b_beat, b_done;

  task automatic snap();
    b_filt = n_filt;
    b_ifm  = n_ifm;
    b_pe   = n_pe;
    b_beat = n_beat;
    b_done = n_done;
  endtask

  task automatic check_counts(input string tag, input int ef, input int ei,
                              input int ep, input int eb, input int ed);
    check({tag, "_filt_hs"}, 64'(n_filt - b_filt), 64'(ef));
    check({tag, "_ifm_hs"},  64'(n_ifm - b_ifm),   64'(ei));
    check({tag, "_pe_cyc"},  64'(n_pe - b_pe),     64'(ep));
    check({tag, "_beats"},   64'(n_beat - b_beat), 64'(eb));
    check({tag, "_done"},    64'(n_done - b_done), 64'(ed));
    check({tag, "_sb_left"}, 64'(exp_q.size()),    64'd0);
  endtask

  task automatic push_pass(input int nt, input int ne, input int nf);
    for (int g = 0; g < nt; g++)
      for (int rw = 0; rw < ne; rw++)
        for (int c = 0; c < nf; c++)
          exp_q.push_back(sb_item(1'b0, PW'(g), CW'(rw), CW'(c)));
    exp_q.push_back(sb_item(1'b1, '0, '0, '0));
  endtask

  task automatic start(input int vp, input int vq, input int vr, input int vt,
                       input int vR, input int vS, input int vH, input int vW);
    @(posedge clk); #1;
    sp = PW'(vp); sq = PW'(vq); sr = PW'(vr); st = PW'(vt);
    s_r = PW'(vR); s_s = PW'(vS); s_h = CW'(vH); s_w = CW'(vW);
    alarm = 1'b1;
    @(posedge clk); #1;
    alarm = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout busy=1 required=0 after %0d cycles", n);
    end
  endtask

  task automatic run_pass(input int vp, input int vq, input int vr, input int vt,
                          input int vR, input int vS, input int vH, input int vW);
    push_pass(vt, vH - vR + 1, vW - vS + 1);
    start(vp, vq, vr, vt, vR, vS, vH, vW);
    wait_idle(2000);
  endtask

  // main sequence
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 64'd0);
`ifdef SEQ_PERF_CNT_EN
    check("reset_perf", {cyc_cnt, stall_cnt}, 64'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // nominal pass: E=F=3, t=4
    snap();
    run_pass(3, 2, 3, 4, 3, 3, 5, 5);
    check_counts("nominal", 4, 12, 108, 36, 1);

    // illegal shape R>H
    snap();
    start(1, 1, 1, 1, 6, 1, 5, 5);
    check("bad_cfg_cycle", 64'({busy, cfg_err}), 64'(2'b10));
    @(posedge clk); #1;
    check("bad_err_cycle", 64'({busy, cfg_err}), 64'(2'b11));
    @(posedge clk); #1;
    check("bad_back_idle", 64'({busy, cfg_err}), 64'(2'b01));
    repeat (2) @(posedge clk); #1;
    check("bad_no_filt_req", 64'(n_filt - b_filt), 64'd0);
    check("bad_no_ifm_req", 64'(n_ifm - b_ifm), 64'd0);

    // filter ack delayed by 7 cycles; accepted alarm also clears cfg_err
    filt_delay = 7;
    push_pass(1, 1, 1);
    start(1, 1, 1, 1, 1, 1, 1, 1);
    check("cfg_err_cleared", 64'(cfg_err), 64'd0);
    wait_idle(200);
    check("stall_req_len", 64'(last_f_run), 64'd8);
    check("stall_ack_pos", 64'(f_ack_at), 64'd7);
`ifdef SEQ_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd7);
    check("cyc_cnt", 64'(cyc_cnt), 64'd13);
`endif
    filt_delay = 0;

    // drain backpressure, ready 1,0,1,0,1 with F=3
    bp_mode = 1'b1;
    snap();
    run_pass(1, 1, 1, 1, 1, 1, 1, 3);
    check("bp_drain_len", 64'(last_v_run), 64'd5);
    check_counts("bp", 1, 1, 3, 3, 1);
    bp_mode = 1'b0;

    // alarm with a different shape during COMPUTE is ignored
    snap();
    push_pass(4, 3, 3);
    start(3, 2, 3, 4, 3, 3, 5, 5);
    n = 0;
    while (!pe_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_alarm_reach_pe", 64'(pe_en), 64'd1);
    @(posedge clk); #1;
    st = PW'(1);
    alarm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    alarm = 1'b0;
    wait_idle(2000);
    check_counts("busy_alarm", 4, 12, 108, 36, 1);

    // reset during COMPUTE of group 1
    snap();
    push_pass(4, 3, 3);
    start(3, 2, 3, 4, 3, 3, 5, 5);
    n = 0;
    while (!(pe_en && grp_idx == PW'(1)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_grp1", 64'({pe_en, grp_idx}), 64'({1'b1, PW'(1)}));
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", out_vec(), 64'd0);
`ifdef SEQ_PERF_CNT_EN
    check("rst_perf", {cyc_cnt, stall_cnt}, 64'd0);
`endif
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(n_done - b_done), 64'd0);

    // fresh full pass after the abort
    snap();
    run_pass(3, 2, 3, 4, 3, 3, 5, 5);
    check_counts("post_rst", 4, 12, 108, 36, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
